// File: rtl/mandelbrot_neuron.sv
`timescale 1ns/1ps
// Escape-time engine: iterates z = z^2 + c in signed Q(WIDTH-FRAC).FRAC from z0 = 0 and tags the count with pixel_id.
// Latency: 2*E cycles from the accept edge to result_valid (E = ADD evaluations); max_iter == 0 answers on the accept edge.
// Backpressure: in_ready is high only while IDLE; result_valid is a one-cycle pulse and cannot be stalled.
// Optional: define MANDEL_NEURON_PERF_EN to add the saturating busy_cycles counter port.
module mandelbrot_neuron #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 28,
    parameter int ITER_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] c_re,
    input  logic signed [WIDTH-1:0] c_im,
    input  logic [15:0]             pixel_id,
    input  logic [ITER_W-1:0]       max_iter,
    output logic                    result_valid,
    output logic [15:0]             result_pixel_id,
    output logic [ITER_W-1:0]       result_iter
`ifdef MANDEL_NEURON_PERF_EN
    ,
    output logic [31:0]             busy_cycles
`endif
);

    // Squares keep four extra integer bits; the magnitude sum needs one more.
    localparam int PW = WIDTH + 4;
    localparam int MW = WIDTH + 5;
    localparam logic signed [MW-1:0]   FOUR    = MW'(1) <<< (FRAC + 2);
    localparam logic [ITER_W-1:0]      ITER_ONE = ITER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ADD
    } state_t;

    // Job fields captured at accept; the scheduler bus is free to move on afterwards.
    typedef struct packed {
        logic [WIDTH-1:0]  c_re;
        logic [WIDTH-1:0]  c_im;
        logic [15:0]       pixel_id;
        logic [ITER_W-1:0] max_iter;
    } job_t;

    state_t                 state;
    job_t                   job;
    logic signed [WIDTH-1:0] z_re;
    logic signed [WIDTH-1:0] z_im;
    logic signed [PW-1:0]   zr2;
    logic signed [PW-1:0]   zi2;
    logic signed [PW-1:0]   zri;
    logic [ITER_W-1:0]      count;

    logic signed [2*WIDTH-1:0] zr_ext, zi_ext;
    logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri;
    logic signed [2*WIDTH-1:0] s_rr, s_ii, s_ri;
    logic signed [MW-1:0]      mag;
    logic signed [MW-1:0]      zr_nx;
    logic signed [MW-1:0]      zi_nx;
    logic [ITER_W-1:0]         count_inc;
    logic                      escaped;
    logic                      capped;

    assign in_ready = (state == S_IDLE);

    // Full-width products rescaled to the Q format, plus the magnitude test and next-z candidates.
    always_comb begin
        zr_ext    = {{WIDTH{z_re[WIDTH-1]}}, z_re};
        zi_ext    = {{WIDTH{z_im[WIDTH-1]}}, z_im};
        p_rr      = zr_ext * zr_ext;
        p_ii      = zi_ext * zi_ext;
        p_ri      = zr_ext * zi_ext;
        s_rr      = p_rr >>> FRAC;
        s_ii      = p_ii >>> FRAC;
        s_ri      = p_ri >>> FRAC;
        mag       = {zr2[PW-1], zr2} + {zi2[PW-1], zi2};
        zr_nx     = {zr2[PW-1], zr2} - {zi2[PW-1], zi2}
                  + {{(MW-WIDTH){job.c_re[WIDTH-1]}}, job.c_re};
        zi_nx     = {zri, 1'b0} + {{(MW-WIDTH){job.c_im[WIDTH-1]}}, job.c_im};
        count_inc = count + ITER_ONE;
        escaped   = (mag > FOUR);
        capped    = (count_inc == job.max_iter);
    end

    // Control FSM with registered result outputs; result_valid defaults low so it only ever pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            job             <= '0;
            z_re            <= '0;
            z_im            <= '0;
            zr2             <= '0;
            zi2             <= '0;
            zri             <= '0;
            count           <= '0;
            result_valid    <= 1'b0;
            result_pixel_id <= '0;
            result_iter     <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        job.c_re     <= c_re;
                        job.c_im     <= c_im;
                        job.pixel_id <= pixel_id;
                        job.max_iter <= max_iter;
                        z_re         <= '0;
                        z_im         <= '0;
                        count        <= '0;
                        if (max_iter == '0) begin
                            // Nothing to iterate: answer immediately and stay available.
                            result_valid    <= 1'b1;
                            result_pixel_id <= pixel_id;
                            result_iter     <= '0;
                        end else begin
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    zr2   <= s_rr[PW-1:0];
                    zi2   <= s_ii[PW-1:0];
                    zri   <= s_ri[PW-1:0];
                    state <= S_ADD;
                end
                S_ADD: begin
                    if (escaped) begin
                        result_valid    <= 1'b1;
                        result_pixel_id <= job.pixel_id;
                        result_iter     <= count;
                        state           <= S_IDLE;
                    end else if (capped) begin
                        result_valid    <= 1'b1;
                        result_pixel_id <= job.pixel_id;
                        result_iter     <= job.max_iter;
                        state           <= S_IDLE;
                    end else begin
                        // Escape test already passed, so z stays in range for legal c.
                        z_re  <= zr_nx[WIDTH-1:0];
                        z_im  <= zi_nx[WIDTH-1:0];
                        count <= count_inc;
                        state <= S_MUL;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MANDEL_NEURON_PERF_EN
    // Saturating count of cycles spent working on a job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cycles <= '0;
        end else if ((state != S_IDLE) && (busy_cycles != 32'hFFFF_FFFF)) begin
            busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mandelbrot_neuron.sv
`timescale 1ns/1ps
// Scoreboard bench for mandelbrot_neuron: directed corner jobs then randomized jobs,
// expected (pixel_id, count, completion cycle) computed from the escape-time rule.
module tb_mandelbrot_neuron;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] c_re;
    logic [31:0] c_im;
    logic [15:0] pixel_id;
    logic [15:0] max_iter;
    logic        result_valid;
    logic [15:0] result_pixel_id;
    logic [15:0] result_iter;
`ifdef MANDEL_NEURON_PERF_EN
    logic [31:0] busy_cycles;
    int          busy_exp = 0;
`endif

    mandelbrot_neuron dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .c_re            (c_re),
        .c_im            (c_im),
        .pixel_id        (pixel_id),
        .max_iter        (max_iter),
        .result_valid    (result_valid),
        .result_pixel_id (result_pixel_id),
        .result_iter     (result_iter)
`ifdef MANDEL_NEURON_PERF_EN
        ,
        .busy_cycles     (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pid;
        int          iter;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Escape-time reference: plain 64-bit arithmetic on Q4.28 values, z wrapped to 32 bits.
    function automatic void model(input logic [31:0] cr32, input logic [31:0] ci32,
                                  input int maxi, output int iter, output int evals);
        longint cr = longint'(int'(cr32));
        longint ci = longint'(int'(ci32));
        longint zr = 0;
        longint zi = 0;
        longint a, b, ab;
        longint four = longint'(4) <<< 28;
        iter  = 0;
        evals = 0;
        for (int n = 0; n < maxi; n++) begin
            a  = (zr * zr) >>> 28;
            b  = (zi * zi) >>> 28;
            ab = (zr * zi) >>> 28;
            if (a + b > four) begin
                iter  = n;
                evals = n + 1;
                return;
            end
            if (n + 1 == maxi) begin
                iter  = maxi;
                evals = maxi;
                return;
            end
            zr = longint'(int'(a - b + cr));
            zi = longint'(int'(2 * ab + ci));
        end
    endfunction

    // Called at a negedge; offers the job as soon as the neuron is idle and records the expectation.
    task automatic issue(input logic [31:0] cr, input logic [31:0] ci,
                         input logic [15:0] pid, input logic [15:0] mi);
        int w = 0;
        int it, ev;
        in_valid = 1'b0;
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("issue_ready_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        c_re     = cr;
        c_im     = ci;
        pixel_id = pid;
        max_iter = mi;
        model(cr, ci, int'(mi), it, ev);
        q.push_back('{pid, it, cyc + 1 + 2 * ev});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            check("drain_timeout_pending", q.size(), 0);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every result pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            if (result_valid) check("result_valid_in_reset", result_valid, 0);
        end else if (result_valid) begin
            if (q.size() == 0) begin
                check("unexpected_result_pulse", result_valid, 0);
            end else begin
                e = q.pop_front();
                check("result_pixel_id", result_pixel_id, e.pid);
                check("result_iter", result_iter, e.iter);
                check("result_cycle", cyc, e.due);
            end
        end
    end

`ifdef MANDEL_NEURON_PERF_EN
    always @(negedge clk) begin
        if (!rst_n) busy_exp = 0;
        else if (!in_ready) busy_exp++;
    end
`endif

    initial begin
        logic [31:0] cr, ci;
        int gap;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        c_re     = '0;
        c_im     = '0;
        pixel_id = '0;
        max_iter = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_result_valid", result_valid, 0);
        check("reset_result_iter", result_iter, 0);
        check("reset_result_pixel_id", result_pixel_id, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // c = 0 never escapes; a competing offer while busy must be ignored.
        issue(32'h0, 32'h0, 16'd5, 16'd16);
        check("busy_in_ready_low", in_ready, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            pixel_id = 16'd999;
            max_iter = 16'd1;
            c_re     = 32'h2800_0000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        issue(32'h0, 32'h0, 16'd6, 16'd16);
        drain();
`ifdef MANDEL_NEURON_PERF_EN
        check("busy_cycles_two_jobs", busy_cycles, 64);
`endif

        // Fast escape, short orbit, and the mag == 4.0 boundary.
        issue(32'h2800_0000, 32'h0, 16'd10, 16'd256);
        drain();
        issue(32'h1000_0000, 32'h0, 16'd11, 16'd256);
        drain();
        issue(32'hE000_0000, 32'h0, 16'd12, 16'd256);
        drain();

        // max_iter == 0 answers at once; the next job is accepted on the following cycle.
        issue(32'h1000_0000, 32'h0, 16'd9, 16'd0);
        check("max0_in_ready_stays", in_ready, 1);
        issue(32'h1000_0000, 32'h0, 16'd13, 16'd256);
        drain();

        // Reset in the middle of a long job abandons it.
        issue(32'h0, 32'h0, 16'd77, 16'd100);
        repeat (19) @(negedge clk);
        check("midjob_busy", in_ready, 0);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midjob_reset_in_ready", in_ready, 1);
        check("midjob_reset_result_valid", result_valid, 0);
        check("midjob_reset_result_iter", result_iter, 0);
        check("midjob_reset_pixel_id", result_pixel_id, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        issue(32'h1000_0000, 32'h0, 16'd78, 16'd256);
        drain();

        // Randomized jobs inside |c| < 2.2 with idle gaps and ignored offers while busy.
        for (int j = 0; j < 40; j++) begin
            cr = 32'($urandom_range(0, 32'h4666_6666)) - 32'h2333_3333;
            ci = 32'($urandom_range(0, 32'h4666_6666)) - 32'h2333_3333;
            issue(cr, ci, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 48)));
            gap = $urandom_range(0, 40);
            for (int g = 0; g < gap; g++) begin
                if (!in_ready && ($urandom_range(0, 1) == 1)) begin
                    in_valid = 1'b1;
                    pixel_id = 16'($urandom_range(0, 65535));
                    max_iter = 16'($urandom_range(0, 5));
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
        drain();
`ifdef MANDEL_NEURON_PERF_EN
        check("busy_cycles_final", busy_cycles, busy_exp);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mandelbrot_neuron.md
Name: mandelbrot_neuron

Overview:
- One escape-time compute element for the Mandelbrot renderer. It sits directly downstream of pixel_scheduler, and N_NEURONS copies hang off the scheduler's shared coordinate bus.
- It accepts one (c_re, c_im, pixel_id) job and iterates z = z² + c in signed Q(WIDTH-FRAC).FRAC fixed point, starting from z0 = 0.
- It returns the pixel_id and the escape iteration count as a single-cycle result pulse.

Parameters:
- WIDTH, 32, coordinate width, signed two's complement.
- FRAC, 28, fractional bits (Q4.28).
- ITER_W, 16, iteration count width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  job offered (scheduler's per-neuron neuron_valid bit).
- in_ready  out  1  neuron idle, can accept a job.
- c_re  in  WIDTH  real part of c, signed.
- c_im  in  WIDTH  imaginary part of c, signed.
- pixel_id  in  16  tag carried through to the result.
- max_iter  in  ITER_W  iteration cap, sampled at accept.
- result_valid  out  1  one-cycle result pulse; no backpressure.
- result_pixel_id  out  16  tag of the completed job.
- result_iter  out  ITER_W  escape count, or max_iter if the point never escaped.

Behaviour:
- Reset: state=IDLE, result_valid=0, result_pixel_id=0, result_iter=0, z=0, count=0. in_ready=1 during and after reset.
- in_ready is decoded combinationally as state==IDLE.
- Accept: happens on the edge where in_valid && in_ready. On that edge:
  - c_re, c_im, pixel_id, max_iter are latched.
  - z_re = z_im = 0, count = 0.
  - Next state is MUL.
  - in_valid while not ready is ignored.
- States: IDLE -> MUL -> ADD -> (MUL | IDLE).
- MUL (1 cycle):
  - Register full 2*WIDTH products zr*zr, zi*zi, zr*zi.
  - Each product is arithmetically shifted right by FRAC and kept at WIDTH+4 bits (no truncation of the integer part).
- ADD (1 cycle):
  - mag = zr2 + zi2, evaluated at WIDTH+5 bits.
  - If mag > 4.0 (strict greater-than; mag == 4.0 does not escape): finish with result_iter = count.
  - Else if count+1 == max_iter: finish with result_iter = max_iter.
  - Else:
    - z_re <= (zr2 - zi2 + c_re) truncated to WIDTH.
    - z_im <= (2*zri + c_im) truncated to WIDTH.
    - count <= count+1.
    - Next state is MUL.
- Finish:
  - result_valid <= 1 for exactly one cycle.
  - result_pixel_id <= latched pixel_id; result_iter as above.
  - State returns to IDLE, so in_ready is high in the same cycle result_valid is high.
  - result_pixel_id and result_iter hold their values until the next finish.
- max_iter == 0:
  - On the accept edge, result_valid <= 1, result_iter <= 0, result_pixel_id <= pixel_id.
  - State stays IDLE.
- Latency: with E = number of ADD evaluations (escape count + 1, or max_iter if capped), result_valid goes high 2E cycles after the accept edge.
- Range rule: |c_re| and |c_im| must be < 4.0. With that bound, z stays inside the WIDTH range because the escape test precedes each update. Out-of-range c gives an undefined count but never hangs, since count still caps at max_iter.
- Reset mid-job: the job is abandoned, no result is emitted, and all values return to their reset values.
- max_iter changing mid-job has no effect on the current job.

Optional Feature:
- Macro MANDEL_NEURON_PERF_EN.
- Defined:
  - Adds output port busy_cycles [31:0].
  - Increments every cycle state != IDLE, saturating at 0xFFFF_FFFF.
  - Cleared only by rst_n.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- c=(0,0), max_iter=16, pixel_id=5 -> result_iter=16, result_pixel_id=5, result_valid high 32 cycles after accept for exactly 1 cycle.
- c=(2.5,0) (0x2800_0000), max_iter=256 -> result_iter=1, latency 4 cycles.
- c=(1.0,0), max_iter=256 -> z sequence 0,1,2,5, result_iter=3, latency 8; c=(-2.0,0) -> mag==4.0 never escapes, result_iter=256.
- max_iter=0, c=(1.0,0), pixel_id=9 -> result_valid with result_iter=0, pixel_id=9 on the cycle after accept; in_ready stays 1. A back-to-back job on the next cycle is accepted.
- Assert rst_n mid-job (c=(0,0), max_iter=100, 20 cycles in) -> no result_valid, in_ready=1. A new job after release completes normally with the correct pixel_id.
- With MANDEL_NEURON_PERF_EN: two jobs (c=(0,0), max 16) -> busy_cycles=64. In_valid asserted while busy is ignored and does not change the latched pixel_id.
